// File: rtl/core_config_pkg.sv
// Shared reset-sequencer types and defaults.
// Optional ack handshake is enabled by RST_SEQ_ACK_EN.
package core_config_pkg;

  localparam int RST_SEQ_DOMAINS    = 3;
  localparam int RST_HOLD_CYCLES    = 16;
  localparam int RST_STAGGER_CYCLES = 4;
  localparam int RST_ACK_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    RST_POR,
    RST_SW,
    RST_WDT,
    RST_DBG
  } rst_cause_t;

  typedef enum logic [1:0] {
    SEQ_RUN,
    SEQ_HOLD,
    SEQ_RELEASE
  } rst_seq_state_t;

  // Importance of a cause; a higher rank may overwrite a lower one.
  function automatic logic [1:0] cause_rank(rst_cause_t c);
    logic [1:0] r;
    unique case (c)
      RST_POR: r = 2'd0;
      RST_SW:  r = 2'd1;
      RST_DBG: r = 2'd2;
      RST_WDT: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request / status bundle of the reset sequencer.
// Optional ack handshake is enabled by RST_SEQ_ACK_EN.
interface reset_sequencer_if
  import core_config_pkg::*;
#(
  parameter int N = RST_SEQ_DOMAINS
);

  logic         sw_req;
  logic         wdt_req;
  logic         dbg_req;
  logic [N-1:0] dom_ack;
  logic [N-1:0] dom_rst;
  logic         seq_busy;
  rst_cause_t   rst_cause;
  logic [7:0]   rst_count;
  logic         ack_err;

  modport master (
    output sw_req, wdt_req, dbg_req, dom_ack,
    input  dom_rst, seq_busy, rst_cause,
    input  rst_count, ack_err
  );

  modport slave (
    input  sw_req, wdt_req, dbg_req, dom_ack,
    output dom_rst, seq_busy, rst_cause,
    output rst_count, ack_err
  );

endinterface

// File: rtl/rst_req_arbiter.sv
// Priority encoder for reset requests.
// Watchdog beats debugger beats software.
module rst_req_arbiter
  import core_config_pkg::*;
(
  input  logic       sw_req,
  input  logic       wdt_req,
  input  logic       dbg_req,
  output logic       req_any,
  output rst_cause_t cause
);

  // Pick the highest-ranked active request.
  always_comb begin
    req_any = sw_req | wdt_req | dbg_req;
    cause   = RST_POR;
    priority case (1'b1)
      wdt_req: cause = RST_WDT;
      dbg_req: cause = RST_DBG;
      sw_req:  cause = RST_SW;
      default: cause = RST_POR;
    endcase
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with cause log.
// Define RST_SEQ_ACK_EN to gate each stage on dom_ack.
module reset_sequencer
  import core_config_pkg::*;
#(
  parameter int N_DOMAINS      = RST_SEQ_DOMAINS,
  parameter int HOLD_CYCLES    = RST_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = RST_STAGGER_CYCLES,
  parameter int ACK_TIMEOUT    = RST_ACK_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int IW = $clog2(N_DOMAINS + 1);

  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0] STAG_INIT = SW'(STAGGER_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS);

  logic       req_any;
  rst_cause_t req_cause;

  rst_req_arbiter u_arb (
    .sw_req  (bus.sw_req),
    .wdt_req (bus.wdt_req),
    .dbg_req (bus.dbg_req),
    .req_any (req_any),
    .cause   (req_cause)
  );

  rst_seq_state_t       state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SW-1:0]        stag_q, stag_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  rst_cause_t           cause_q, cause_d;
  logic [7:0]           count_q, count_d;
  logic                 rel;

`ifdef RST_SEQ_ACK_EN
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACNT_LAST = AW'(ACK_TIMEOUT - 1);

  logic          wait_q, wait_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          err_q, err_d;
  logic          ack_cur;
`else
  localparam int unused_timeout = ACK_TIMEOUT;
  wire unused_ack = ^bus.dom_ack;
`endif

  // Next-state, counters and reset outputs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    cause_d = cause_q;
    count_d = count_q;
    rel     = 1'b0;
`ifdef RST_SEQ_ACK_EN
    wait_d  = wait_q;
    acnt_d  = acnt_q;
    err_d   = err_q;
    ack_cur = 1'b0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (IW'(i + 1) == idx_q) ack_cur = bus.dom_ack[i];
    end
`endif
    if (req_any && state_q != SEQ_HOLD) begin
      state_d = SEQ_HOLD;
      dom_d   = '1;
      hold_d  = HOLD_INIT;
      cause_d = req_cause;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end else begin
      unique case (state_q)
        SEQ_RUN: ;
        SEQ_HOLD: begin
          dom_d = '1;
          if (req_any) begin
            hold_d = HOLD_INIT;
            if (cause_rank(req_cause) > cause_rank(cause_q))
              cause_d = req_cause;
          end else if (hold_q <= HW'(1)) begin
            state_d  = SEQ_RELEASE;
            dom_d[0] = 1'b0;
            idx_d    = IW'(1);
            stag_d   = STAG_INIT;
`ifdef RST_SEQ_ACK_EN
            wait_d   = 1'b1;
            acnt_d   = '0;
`endif
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        SEQ_RELEASE: begin
`ifdef RST_SEQ_ACK_EN
          if (wait_q) begin
            if (ack_cur || acnt_q == ACNT_LAST) begin
              wait_d = 1'b0;
              if (!ack_cur) err_d = 1'b1;
              if (idx_q == IDX_LAST) state_d = SEQ_RUN;
              else if (!ack_cur) stag_d = STAG_INIT;
              else if (STAGGER_CYCLES == 1) rel = 1'b1;
              else stag_d = STAG_INIT - SW'(1);
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end else if (stag_q == SW'(1)) begin
            rel = 1'b1;
          end else begin
            stag_d = stag_q - SW'(1);
          end
`else
          if (idx_q == IDX_LAST) state_d = SEQ_RUN;
          else if (stag_q == SW'(1)) rel = 1'b1;
          else stag_d = stag_q - SW'(1);
`endif
          if (rel) begin
            for (int i = 0; i < N_DOMAINS; i++) begin
              if (IW'(i) == idx_q) dom_d[i] = 1'b0;
            end
            idx_d  = idx_q + IW'(1);
            stag_d = STAG_INIT;
`ifdef RST_SEQ_ACK_EN
            wait_d = 1'b1;
            acnt_d = '0;
`endif
          end
        end
        default: state_d = SEQ_HOLD;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_HOLD;
      hold_q  <= HOLD_INIT;
      stag_q  <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      cause_q <= RST_POR;
      count_q <= '0;
`ifdef RST_SEQ_ACK_EN
      wait_q  <= 1'b0;
      acnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      cause_q <= cause_d;
      count_q <= count_d;
`ifdef RST_SEQ_ACK_EN
      wait_q  <= wait_d;
      acnt_q  <= acnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.dom_rst   = dom_q;
  assign bus.seq_busy  = (state_q != SEQ_RUN);
  assign bus.rst_cause = cause_q;
  assign bus.rst_count = count_q;
`ifdef RST_SEQ_ACK_EN
  assign bus.ack_err   = err_q;
`else
  assign bus.ack_err   = 1'b0;
`endif

endmodule
